load_store_sequencer: RTL and testbench

Sequences CPU load/store requests onto the word-addressed, edge-strobed memory interface that sits directly downstream. It accepts one byte-addressed request at a time with a RISC-V `funct3` size code, converts it to a word index, and emits one-cycle `read_enable`/`write_enable` pulses. Sub-word stores are done as read-modify-write, because the memory below only writes whole words. Load data is lane-extracted and sign- or zero-extended before being returned on a single-cycle response strobe.

---
 rtl/load_store_sequencer_if.sv | 32 +++
 rtl/load_store_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_load_store_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_sequencer_if.sv
// Request/response and downstream-memory bundle for load_store_sequencer.
// master = CPU plus memory side, slave = the sequencer itself.
interface load_store_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_store_data;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_load_data;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_store_data,
        input  req_ready, resp_valid, resp_error, resp_load_data,
        input  mem_address, mem_write_data, mem_write_enable, mem_read_enable,
        output mem_read_data
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_store_data,
        output req_ready, resp_valid, resp_error, resp_load_data,
        output mem_address, mem_write_data, mem_write_enable, mem_read_enable,
        input  mem_read_data
    );
endinterface

// File: rtl/load_store_sequencer.sv
// Byte-addressed load/store sequencer onto a word-wide, edge-strobed memory.
// Define LSU_MISALIGN_CHECK_EN to flag misaligned H/W accesses instead of force-aligning them.
module load_store_sequencer #(
    parameter int ADDRESS_WIDTH    = 8,
    parameter int READ_WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    load_store_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } state_t;

    localparam int CNT_W = (READ_WAIT_CYCLES > 1) ? $clog2(READ_WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_WAIT_CYCLES - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic               write_reg;
    logic [2:0]         funct3_reg;
    logic [1:0]         offset_reg;
    logic [15:0]        store_data_reg;

    logic               req_ready_reg;
    logic               resp_valid_reg;
    logic               resp_error_reg;
    logic [31:0]        resp_load_data_reg;
    logic [31:0]        mem_address_reg;
    logic [31:0]        mem_write_data_reg;
    logic               mem_write_enable_reg;
    logic               mem_read_enable_reg;

    assign bus.req_ready        = req_ready_reg;
    assign bus.resp_valid       = resp_valid_reg;
    assign bus.resp_error       = resp_error_reg;
    assign bus.resp_load_data   = resp_load_data_reg;
    assign bus.mem_address      = mem_address_reg;
    assign bus.mem_write_data   = mem_write_data_reg;
    assign bus.mem_write_enable = mem_write_enable_reg;
    assign bus.mem_read_enable  = mem_read_enable_reg;

    // Address bits above the memory's byte range wrap away.
    logic unused_address_bits;
    assign unused_address_bits = ^bus.req_address[31:ADDRESS_WIDTH+2];

    logic [31:0] req_word_index;
    assign req_word_index = 32'(bus.req_address[ADDRESS_WIDTH+1:2]);

    logic       funct3_illegal;
    logic       misaligned;
    logic       req_error;
    logic       word_store;
    logic [1:0] req_offset;

    always_comb begin
        funct3_illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                         (bus.req_funct3 == 3'd7) || (bus.req_write && bus.req_funct3[2]);
        misaligned     = 1'b0;
        req_offset     = bus.req_address[1:0];
`ifdef LSU_MISALIGN_CHECK_EN
        misaligned = ((bus.req_funct3[1:0] == 2'd1) && bus.req_address[0]) ||
                     ((bus.req_funct3[1:0] == 2'd2) && (bus.req_address[1:0] != 2'b00));
`else
        if (bus.req_funct3[1:0] == 2'd1) begin
            req_offset[0] = 1'b0;
        end else if (bus.req_funct3[1:0] == 2'd2) begin
            req_offset = 2'b00;
        end
`endif
        req_error  = funct3_illegal || misaligned;
        word_store = bus.req_write && (bus.req_funct3 == 3'd2);
    end

    // Read-modify-write merge: each byte lane takes store data when the access covers it.
    logic [31:0] merged_word;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_hit;
            logic [7:0] lane_src;
            assign lane_hit = (funct3_reg[1:0] == 2'd0) ? (offset_reg == 2'(gi))
                                                        : (offset_reg[1] == 1'(gi / 2));
            assign lane_src = (funct3_reg[1:0] == 2'd0) ? store_data_reg[7:0]
                                                        : store_data_reg[(gi % 2) * 8 +: 8];
            assign merged_word[gi * 8 +: 8] = lane_hit ? lane_src
                                                       : bus.mem_read_data[gi * 8 +: 8];
        end
    endgenerate

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        load_signed;
    logic [31:0] load_extended;

    always_comb begin
        load_byte     = bus.mem_read_data[{offset_reg, 3'b000} +: 8];
        load_half     = offset_reg[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        load_signed   = ~funct3_reg[2];
        load_extended = bus.mem_read_data;
        case (funct3_reg[1:0])
            2'd0:    load_extended = {{24{load_signed & load_byte[7]}}, load_byte};
            2'd1:    load_extended = {{16{load_signed & load_half[15]}}, load_half};
            default: load_extended = bus.mem_read_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg            <= ST_IDLE;
            wait_cnt_reg         <= '0;
            write_reg            <= 1'b0;
            funct3_reg           <= 3'd0;
            offset_reg           <= 2'd0;
            store_data_reg       <= 16'd0;
            req_ready_reg        <= 1'b1;
            resp_valid_reg       <= 1'b0;
            resp_error_reg       <= 1'b0;
            resp_load_data_reg   <= 32'd0;
            mem_address_reg      <= 32'd0;
            mem_write_data_reg   <= 32'd0;
            mem_write_enable_reg <= 1'b0;
            mem_read_enable_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        write_reg      <= bus.req_write;
                        funct3_reg     <= bus.req_funct3;
                        offset_reg     <= req_offset;
                        store_data_reg <= bus.req_store_data[15:0];
                        req_ready_reg  <= 1'b0;
                        if (req_error) begin
                            state_reg          <= ST_RESP;
                            resp_valid_reg     <= 1'b1;
                            resp_error_reg     <= 1'b1;
                            resp_load_data_reg <= 32'd0;
                        end else if (word_store) begin
                            state_reg            <= ST_WRITE;
                            mem_address_reg      <= req_word_index;
                            mem_write_data_reg   <= bus.req_store_data;
                            mem_write_enable_reg <= 1'b1;
                        end else begin
                            state_reg           <= ST_READ;
                            mem_address_reg     <= req_word_index;
                            mem_read_enable_reg <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    mem_read_enable_reg <= 1'b0;
                    wait_cnt_reg        <= WAIT_LOAD;
                    state_reg           <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        if (write_reg) begin
                            mem_write_data_reg   <= merged_word;
                            mem_write_enable_reg <= 1'b1;
                            state_reg            <= ST_WRITE;
                        end else begin
                            resp_valid_reg     <= 1'b1;
                            resp_error_reg     <= 1'b0;
                            resp_load_data_reg <= load_extended;
                            state_reg          <= ST_RESP;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    mem_write_enable_reg <= 1'b0;
                    resp_valid_reg       <= 1'b1;
                    resp_error_reg       <= 1'b0;
                    resp_load_data_reg   <= 32'd0;
                    state_reg            <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_reg     <= 1'b0;
                    resp_error_reg     <= 1'b0;
                    resp_load_data_reg <= 32'd0;
                    req_ready_reg      <= 1'b1;
                    state_reg          <= ST_IDLE;
                end
                default: begin
                    state_reg            <= ST_IDLE;
                    req_ready_reg        <= 1'b1;
                    resp_valid_reg       <= 1'b0;
                    mem_write_enable_reg <= 1'b0;
                    mem_read_enable_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer: transaction-level model plus per-cycle compare.
module tb_load_store_sequencer;
    localparam int AW = 8;
    localparam int RW = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    load_store_sequencer_if bus ();

    load_store_sequencer #(.ADDRESS_WIDTH(AW), .READ_WAIT_CYCLES(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench memory: sampled strobes, read data registered one cycle after the read strobe.
    logic [31:0] bench_mem [0:255] = '{default: 32'd0};
    logic [31:0] model_mem [0:255] = '{default: 32'd0};
    int rd_count = 0;
    int wr_count = 0;
    initial bus.mem_read_data = 32'd0;
    always @(posedge clk) begin
        if (bus.mem_read_enable === 1'b1) begin
            bus.mem_read_data <= bench_mem[bus.mem_address[7:0]];
            rd_count <= rd_count + 1;
        end
        if (bus.mem_write_enable === 1'b1) begin
            bench_mem[bus.mem_address[7:0]] <= bus.mem_write_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected transaction, filled by the model at acceptance.
    bit          chk_en = 1'b0;
    bit          active = 1'b0;
    int          acc = 0;
    int          lat = 0;
    int          wr_off = 0;
    bit          need_rd = 1'b0;
    bit          need_wr = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    int          m_idx = 0;
    logic        last_err;
    logic [31:0] last_data;

    task automatic model_txn(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
        int size = int'(f3) % 4;
        bit sgn = (f3 < 3'd4);
        int offs = int'(a % 4);
        bit illegal;
        bit mis;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] v;
        illegal = (f3 == 3'd3) || (f3 >= 3'd6) || (w && f3 >= 3'd4);
        mis = (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0);
`ifdef LSU_MISALIGN_CHECK_EN
        m_err = illegal || mis;
`else
        m_err = illegal;
        if (size == 1) offs = offs - (offs % 2);
        if (size == 2) offs = 0;
`endif
        m_idx = int'((a / 4) % 256);
        word = model_mem[m_idx];
        mask = (size == 0) ? 32'hFF : 32'hFFFF;
        m_data = 32'd0;
        m_wdata = 32'd0;
        need_rd = 1'b0;
        need_wr = 1'b0;
        wr_off = 0;
        if (m_err) begin
            lat = 0;
        end else if (w) begin
            need_wr = 1'b1;
            if (size == 2) begin
                lat = 1;
                m_wdata = d;
            end else begin
                need_rd = 1'b1;
                lat = 2 + RW;
                wr_off = 1 + RW;
                m_wdata = (word & ~(mask << (8 * offs))) | ((d & mask) << (8 * offs));
            end
            model_mem[m_idx] = m_wdata;
        end else begin
            need_rd = 1'b1;
            lat = 1 + RW;
            v = word >> (8 * offs);
            if (size == 0) begin
                v = v & 32'hFF;
                if (sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
            end else if (size == 1) begin
                v = v & 32'hFFFF;
                if (sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
            end
            m_data = v;
        end
    endtask

    // Per-cycle compare of every output against the expected transaction timeline.
    always @(negedge clk) begin
        if (chk_en) begin
            bit in_txn;
            bit exp_rv;
            bit exp_re;
            bit exp_we;
            in_txn = active && cyc >= acc && cyc <= acc + lat;
            exp_rv = active && cyc == acc + lat;
            exp_re = active && need_rd && cyc == acc;
            exp_we = active && need_wr && cyc == acc + wr_off;
            chk("req_ready", 32'(bus.req_ready), 32'(!in_txn));
            chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
            chk("mem_read_enable", 32'(bus.mem_read_enable), 32'(exp_re));
            chk("mem_write_enable", 32'(bus.mem_write_enable), 32'(exp_we));
            if (exp_re || exp_we) chk("mem_address", bus.mem_address, 32'(m_idx));
            if (exp_we) chk("mem_write_data", bus.mem_write_data, m_wdata);
            if (exp_rv) begin
                chk("resp_error", 32'(bus.resp_error), 32'(m_err));
                chk("resp_load_data", bus.resp_load_data, m_data);
            end
            if (bus.resp_valid === 1'b1) begin
                last_err  = bus.resp_error;
                last_data = bus.resp_load_data;
            end
        end
    end

    task automatic do_req(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d,
                          input bit lit_err, input bit [31:0] lit_data);
        int n = 0;
        int rd0;
        int wr0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(bus.req_ready), 32'd1);
        last_err  = 1'bx;
        last_data = 'x;
        model_txn(w, f3, a, d);
        acc = cyc + 1;
        active = 1'b1;
        rd0 = rd_count;
        wr0 = wr_count;
        bus.req_valid      = 1'b1;
        bus.req_write      = w;
        bus.req_funct3     = f3;
        bus.req_address    = a;
        bus.req_store_data = d;
        @(negedge clk);
        // Scramble the request after acceptance; the DUT must use its captured copy.
        bus.req_valid      = 1'b0;
        bus.req_write      = ~w;
        bus.req_funct3     = 3'd7;
        bus.req_address    = ~a;
        bus.req_store_data = ~d;
        repeat (lat + 1) @(negedge clk);
        chk("resp_error_lit", 32'(last_err), 32'(lit_err));
        chk("resp_data_lit", last_data, lit_data);
        chk("read_pulses", 32'(rd_count - rd0), 32'(need_rd));
        chk("write_pulses", 32'(wr_count - wr0), 32'(need_wr));
        $display("txn w=%0d f3=%0d addr=%h data=%h -> err=%0b load=%h", w, f3, a, d, last_err, last_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int wr_before;
        bus.req_valid      = 1'b0;
        bus.req_write      = 1'b0;
        bus.req_funct3     = 3'd0;
        bus.req_address    = 32'd0;
        bus.req_store_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
        chk("rst_resp_load_data", bus.resp_load_data, 32'd0);
        chk("rst_mem_address", bus.mem_address, 32'd0);
        chk("rst_mem_write_data", bus.mem_write_data, 32'd0);
        chk("rst_mem_write_enable", 32'(bus.mem_write_enable), 32'd0);
        chk("rst_mem_read_enable", 32'(bus.mem_read_enable), 32'd0);
        reset = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        chk("mem4_sw", bench_mem[4], 32'hDEADBEEF);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        do_req(1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, 32'h0);
        do_req(1'b1, 3'd0, 32'h13, 32'h12345680, 1'b0, 32'h0);
        chk("mem4_sb", bench_mem[4], 32'h80223344);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 32'h00000080);
        do_req(1'b1, 3'd1, 32'h22, 32'h5555ABCD, 1'b0, 32'h0);
        chk("mem8_sh", bench_mem[8], 32'hABCD0000);
        do_req(1'b0, 3'd1, 32'h22, 32'h0, 1'b0, 32'hFFFFABCD);
        do_req(1'b0, 3'd5, 32'h22, 32'h0, 1'b0, 32'h0000ABCD);
        do_req(1'b1, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        do_req(1'b0, 3'd2, 32'h401, 32'h0, 1'b1, 32'h0);
        do_req(1'b0, 3'd1, 32'h23, 32'h0, 1'b1, 32'h0);
`else
        do_req(1'b0, 3'd2, 32'h401, 32'h0, 1'b0, 32'hCAFEF00D);
        do_req(1'b0, 3'd1, 32'h23, 32'h0, 1'b0, 32'hFFFFABCD);
`endif
        do_req(1'b0, 3'd3, 32'h0, 32'h0, 1'b1, 32'h0);
        do_req(1'b1, 3'd4, 32'h13, 32'h000000FF, 1'b1, 32'h0);
        chk("mem4_after_sbu", bench_mem[4], 32'h80223344);
        do_req(1'b0, 3'd7, 32'h10, 32'h0, 1'b1, 32'h0);
        do_req(1'b0, 3'd2, 32'hFFFFFC10, 32'h0, 1'b0, 32'h80223344);
        do_req(1'b0, 3'd0, 32'h22, 32'h0, 1'b0, 32'hFFFFFFCD);

        // Reset during WAIT of a sub-word store: no write, no response, instant IDLE.
        chk_en = 1'b0;
        active = 1'b0;
        wr_before = wr_count;
        bus.req_valid      = 1'b1;
        bus.req_write      = 1'b1;
        bus.req_funct3     = 3'd0;
        bus.req_address    = 32'h21;
        bus.req_store_data = 32'h77;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort_write_enable", 32'(bus.mem_write_enable), 32'd0);
        chk("abort_read_enable", 32'(bus.mem_read_enable), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_mem8", bench_mem[8], 32'hABCD0000);
        chk("abort_no_write", 32'(wr_count - wr_before), 32'd0);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'hABCD0000);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
